ro_meas_array: RTL and testbench
================================

Name: ro_meas_array

Overview:
- Parametrised multi-channel ring-oscillator frequency measurement engine for the PUF datapath.
- Synchronises C_IOSCNUM free-running oscillator inputs and counts each one's rising edges over a programmable window of I_sclk cycles.
- Compares neighbouring counts to form a response word and holds per-channel counts for readback.
- Successor to the fixed-window meas core: adds configurable window, per-channel enable mask, saturation flags, abort and count readback.

Parameters:
- C_IOSCNUM, 10, number of oscillator channels (>=2).
- C_CNTWIDTH, 24, per-channel edge counter width.
- C_WINWIDTH, 16, width of the window-length input.
- C_SELWIDTH, 4, readback select width (>= clog2(C_IOSCNUM)).

Ports:
- I_sclk  in  1  system clock.
- I_rst  in  1  reset.
- I_osc  in  C_IOSCNUM  asynchronous oscillator inputs.
- I_start  in  1  start-measurement strobe.
- I_abort  in  1  abort current measurement.
- I_win  in  C_WINWIDTH  window length in I_sclk cycles; latched at start.
- I_en  in  C_IOSCNUM  channel enable mask; latched at start.
- I_rd_sel  in  C_SELWIDTH  readback channel select.
- O_busy  out  1  high in every state except IDLE.
- O_valid  out  1  one-cycle pulse when O_resp updates.
- O_resp  out  C_IOSCNUM-1  response bits.
- O_sat  out  C_IOSCNUM  per-channel saturation flags.
- O_rd_cnt  out  C_CNTWIDTH  count of the selected channel.

Behaviour:
- Clock and reset: single clock I_sclk. Reset I_rst is asynchronous and active-high.
- Reset state: all outputs 0, FSM in IDLE, counters, sync flops, latched win/en all 0.
- Input synchroniser: each I_osc[i] passes through a 2-FF synchroniser plus a third flop. A rising edge is sync2 & ~sync3.
- Frequency limit: correct counting is guaranteed only for f_osc < f_sclk/2. Higher frequencies undercount; no error is flagged.
- FSM states: IDLE -> CLEAR -> COUNT -> COMPARE -> DONE -> IDLE.
- IDLE:
  - I_start=1 latches I_win and I_en and moves to CLEAR.
  - I_start while not IDLE is ignored.
- CLEAR (1 cycle): zero all counters and O_sat, and load the window counter.
- COUNT:
  - Lasts exactly W = latched I_win cycles.
  - Each enabled channel increments on every edge detected during those cycles.
  - A disabled channel stays 0.
  - W=0: COUNT is skipped (CLEAR goes straight to COMPARE); all counts are 0.
- Saturation: counters saturate at all-ones, with no wrap. On reaching all-ones, O_sat[i] sets and holds until the next CLEAR.
- COMPARE:
  - Lasts C_IOSCNUM-1 cycles, evaluating one pair per cycle, k = 0..N-2.
  - resp_k = (cnt[k] > cnt[k+1]), unsigned strict; a tie gives 0.
  - Results go to a shadow register; O_resp is not updated until DONE.
- DONE (1 cycle): O_resp <= shadow, O_valid=1, then IDLE.
- Latency: start sampled at cycle T gives O_valid at T + W + C_IOSCNUM + 1. O_busy is high from T+1 through the DONE cycle inclusive.
- I_abort:
  - In any non-IDLE state, the next state is IDLE.
  - O_resp is unchanged and no O_valid is issued.
  - Counts and O_sat keep their partial values.
  - If I_abort and I_start are both high in IDLE, abort wins and start is ignored.
- Simultaneous edge and saturation: the counter stays at max and O_sat is set.
- Reset mid-operation: immediate return to the reset state; O_resp is cleared.
- Readback: O_rd_cnt = cnt[I_rd_sel], registered, with 1-cycle latency. I_rd_sel >= C_IOSCNUM returns 0.
- Count retention: counts hold after DONE until the next CLEAR. Readback during COUNT returns the live, changing value.

Test Plan:
- Descending frequencies: osc i toggles every (i+2) sclk cycles, I_win=1000, I_en=all ones. Required: cnt0≈250, cnt1≈166, cnt2=125 (±1); O_resp=9'h1FF; O_valid exactly at T+1011.
- Ascending frequencies: osc i toggles every (11-i) cycles, I_win=1000. Required: O_resp=9'h000.
- Equal counts: all channels share one toggle-every-3 source. Required: all counts equal (166/167 ±1); O_resp=0 for every tie pair.
- Saturation: C_CNTWIDTH=4, I_win=100, osc0 toggles every 2 cycles, others held low. Required: cnt0=15, O_sat=10'h001, O_resp[0]=1.
- Enable mask: I_en=10'h3FE, osc0 fastest. Required: O_rd_cnt with sel=0 reads 0; O_resp[0]=0; sel=12 reads 0.
- Control corner cases:
  - I_start pulsed mid-COUNT: ignored, single O_valid.
  - I_abort at COUNT cycle 50: O_busy low next cycle, no O_valid, O_resp retains the previous value.
  - I_rst asserted mid-COMPARE: all outputs 0 asynchronously.
  - I_win=0: O_valid at T+11 with O_resp=0.

Source files
------------

// File: rtl/ro_meas_array.sv
// rtl/ro_meas_array.sv - multi-channel ring-oscillator edge counter with neighbour-compare response
module ro_meas_array #(
    parameter int C_IOSCNUM  = 10,
    parameter int C_CNTWIDTH = 24,
    parameter int C_WINWIDTH = 16,
    parameter int C_SELWIDTH = 4
) (
    input  logic                  I_sclk,
    input  logic                  I_rst,
    input  logic [C_IOSCNUM-1:0]  I_osc,
    input  logic                  I_start,
    input  logic                  I_abort,
    input  logic [C_WINWIDTH-1:0] I_win,
    input  logic [C_IOSCNUM-1:0]  I_en,
    input  logic [C_SELWIDTH-1:0] I_rd_sel,
    output logic                  O_busy,
    output logic                  O_valid,
    output logic [C_IOSCNUM-2:0]  O_resp,
    output logic [C_IOSCNUM-1:0]  O_sat,
    output logic [C_CNTWIDTH-1:0] O_rd_cnt
);
    localparam int KW = (C_IOSCNUM > 2) ? $clog2(C_IOSCNUM - 1) : 1;

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_COUNT, S_COMPARE, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [C_IOSCNUM-1:0]    sync1_q, sync2_q, sync3_q;
    logic [C_WINWIDTH-1:0]   win_lat_q, win_lat_d, win_q, win_d;
    logic [C_IOSCNUM-1:0]    en_q, en_d, sat_q, sat_d;
    logic [C_CNTWIDTH-1:0]   cnt_q [C_IOSCNUM];
    logic [C_CNTWIDTH-1:0]   cnt_d [C_IOSCNUM];
    logic [C_IOSCNUM-2:0]    shadow_q, shadow_d, resp_q, resp_d;
    logic [KW-1:0]           k_q, k_d;
    logic [C_CNTWIDTH-1:0]   rd_cnt_q, rd_cnt_d;
    logic [C_IOSCNUM-1:0]    rise;
    logic                    gt;

    assign rise = sync2_q & ~sync3_q;

    always_comb begin
        state_d   = state_q;
        win_lat_d = win_lat_q;
        en_d      = en_q;
        win_d     = win_q;
        sat_d     = sat_q;
        cnt_d     = cnt_q;
        shadow_d  = shadow_q;
        resp_d    = resp_q;
        k_d       = k_q;
        rd_cnt_d  = '0;
        gt        = 1'b0;

        for (int i = 0; i < C_IOSCNUM - 1; i++) begin
            if (k_q == KW'(i)) gt = (cnt_q[i] > cnt_q[i+1]);
        end
        for (int i = 0; i < C_IOSCNUM; i++) begin
            if (I_rd_sel == C_SELWIDTH'(i)) rd_cnt_d = cnt_q[i];
        end

        case (state_q)
            S_IDLE: begin
                if (I_start && !I_abort) begin
                    win_lat_d = I_win;
                    en_d      = I_en;
                    state_d   = S_CLEAR;
                end
            end
            S_CLEAR: begin
                cnt_d   = '{default: '0};
                sat_d   = '0;
                win_d   = win_lat_q;
                k_d     = '0;
                state_d = (win_lat_q == '0) ? S_COMPARE : S_COUNT;
            end
            S_COUNT: begin
                win_d = win_q - C_WINWIDTH'(1);
                for (int i = 0; i < C_IOSCNUM; i++) begin
                    if (en_q[i] && rise[i] && (cnt_q[i] != '1))
                        cnt_d[i] = cnt_q[i] + C_CNTWIDTH'(1);
                    if (cnt_d[i] == '1) sat_d[i] = 1'b1;
                end
                if (win_q == C_WINWIDTH'(1)) state_d = S_COMPARE;
            end
            S_COMPARE: begin
                for (int i = 0; i < C_IOSCNUM - 1; i++) begin
                    if (k_q == KW'(i)) shadow_d[i] = gt;
                end
                k_d = k_q + KW'(1);
                // Publish on the final pair so O_resp changes together with O_valid in DONE
                if (k_q == KW'(C_IOSCNUM - 2)) begin
                    state_d = S_DONE;
                    resp_d  = shadow_d;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (state_q != S_IDLE && I_abort) begin
            state_d = S_IDLE;
            resp_d  = resp_q;
        end
    end

    always_ff @(posedge I_sclk or posedge I_rst) begin
        if (I_rst) begin
            state_q   <= S_IDLE;
            sync1_q   <= '0;
            sync2_q   <= '0;
            sync3_q   <= '0;
            win_lat_q <= '0;
            en_q      <= '0;
            win_q     <= '0;
            sat_q     <= '0;
            cnt_q     <= '{default: '0};
            shadow_q  <= '0;
            resp_q    <= '0;
            k_q       <= '0;
            rd_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= I_osc;
            sync2_q   <= sync1_q;
            sync3_q   <= sync2_q;
            win_lat_q <= win_lat_d;
            en_q      <= en_d;
            win_q     <= win_d;
            sat_q     <= sat_d;
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
            resp_q    <= resp_d;
            k_q       <= k_d;
            rd_cnt_q  <= rd_cnt_d;
        end
    end

    assign O_busy   = (state_q != S_IDLE);
    assign O_valid  = (state_q == S_DONE);
    assign O_resp   = resp_q;
    assign O_sat    = sat_q;
    assign O_rd_cnt = rd_cnt_q;
endmodule

// File: tb/tb_ro_meas_array.sv
// tb/tb_ro_meas_array.sv - directed bench for ro_meas_array
module tb_ro_meas_array;
    localparam int N = 10;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   osc = '0;
    logic           start, abort;
    logic [15:0]    win;
    logic [N-1:0]   en;
    logic [3:0]     sel;
    logic           busy, valid, s_busy, s_valid;
    logic [N-2:0]   resp, s_resp;
    logic [N-1:0]   sat, s_sat;
    logic [23:0]    rdcnt;
    logic [3:0]     s_rdcnt;

    int n_cmp = 0;
    int n_err = 0;
    int per[N];
    int divc[N] = '{default: 0};
    bit shared = 1'b0;

    always #5 clk = ~clk;

    ro_meas_array dut (
        .I_sclk(clk), .I_rst(rst), .I_osc(osc), .I_start(start), .I_abort(abort),
        .I_win(win), .I_en(en), .I_rd_sel(sel), .O_busy(busy), .O_valid(valid),
        .O_resp(resp), .O_sat(sat), .O_rd_cnt(rdcnt)
    );

    ro_meas_array #(.C_CNTWIDTH(4)) dut_sat (
        .I_sclk(clk), .I_rst(rst), .I_osc(osc), .I_start(start), .I_abort(abort),
        .I_win(win), .I_en(en), .I_rd_sel(sel), .O_busy(s_busy), .O_valid(s_valid),
        .O_resp(s_resp), .O_sat(s_sat), .O_rd_cnt(s_rdcnt)
    );

    // osc i toggles every per[i] sclk cycles; per 0 holds it low
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (per[i] == 0) begin
                osc[i]  = 1'b0;
                divc[i] = 0;
            end else begin
                divc[i]++;
                if (divc[i] >= per[i]) begin
                    divc[i] = 0;
                    osc[i]  = ~osc[i];
                end
            end
            if (shared && i > 0) osc[i] = osc[0];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_desc();
        for (int i = 0; i < N; i++) per[i] = i + 2;
    endtask

    task automatic set_asc();
        for (int i = 0; i < N; i++) per[i] = 11 - i;
    endtask

    task automatic rd(input int s, output int c, output int sc);
        @(negedge clk);
        sel = 4'(s);
        @(negedge clk);
        c  = int'(rdcnt);
        sc = int'(s_rdcnt);
    endtask

    task automatic run(input int w, input logic [N-1:0] m, input int st_at, input int ab_at,
                       output int lat, output int nval, output logic busy_ab);
        @(negedge clk);
        win = 16'(w); en = m; start = 1'b1; abort = 1'b0;
        lat = -1; nval = 0; busy_ab = 1'b1;
        for (int j = 0; j < w + 40; j++) begin
            @(negedge clk);
            if (valid) begin
                nval++;
                if (lat < 0) lat = j + 1;
            end
            if (j == ab_at + 1) busy_ab = busy;
            start = (j == st_at);
            abort = (j == ab_at);
        end
        start = 1'b0; abort = 1'b0;
    endtask

    int   lat, nval, c, sc;
    logic bab;

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; win = '0; en = '0; sel = '0;
        for (int i = 0; i < N; i++) per[i] = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_valid", valid, 0);
        check("rst_resp", resp, 0);
        check("rst_sat", sat, 0);
        check("rst_rdcnt", rdcnt, 0);

        set_desc();
        run(1000, '1, -1, -1, lat, nval, bab);
        check("desc_lat", lat, 1011);
        check("desc_nval", nval, 1);
        check("desc_resp", resp, 9'h1FF);
        rd(0, c, sc); check("desc_cnt0", (c >= 249 && c <= 251), 1);
        rd(1, c, sc); check("desc_cnt1", (c >= 165 && c <= 167), 1);
        rd(2, c, sc); check("desc_cnt2", (c >= 124 && c <= 126), 1);

        set_asc();
        run(1000, '1, -1, -1, lat, nval, bab);
        check("asc_resp", resp, 9'h000);

        for (int i = 0; i < N; i++) per[i] = 3;
        shared = 1'b1;
        run(1000, '1, -1, -1, lat, nval, bab);
        check("eq_resp", resp, 9'h000);
        rd(0, c, sc); check("eq_cnt0", (c >= 165 && c <= 168), 1);
        rd(9, c, sc); check("eq_cnt9", (c >= 165 && c <= 168), 1);
        shared = 1'b0;

        for (int i = 0; i < N; i++) per[i] = 0;
        per[0] = 2;
        run(100, '1, -1, -1, lat, nval, bab);
        check("sat_resp", s_resp, 9'h001);
        check("sat_flags", s_sat, 10'h001);
        rd(0, c, sc); check("sat_cnt0", sc, 15);

        set_desc();
        run(1000, 10'h3FE, -1, -1, lat, nval, bab);
        check("en_resp", resp, 9'h1FE);
        rd(0, c, sc);  check("en_cnt0", c, 0);
        rd(12, c, sc); check("en_sel12", c, 0);
        rd(1, c, sc);  check("en_cnt1", (c >= 165 && c <= 167), 1);

        run(1000, '1, 500, -1, lat, nval, bab);
        check("midstart_nval", nval, 1);
        check("midstart_lat", lat, 1011);
        check("midstart_resp", resp, 9'h1FF);

        set_asc();
        run(1000, '1, -1, 50, lat, nval, bab);
        check("abort_busy", bab, 0);
        check("abort_nval", nval, 0);
        check("abort_resp", resp, 9'h1FF);

        set_desc();
        sel = 4'd0;
        @(negedge clk);
        win = 16'd20; en = '1; start = 1'b1;
        for (int j = 0; j <= 24; j++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("cmp_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_valid", valid, 0);
        check("arst_resp", resp, 0);
        check("arst_sat", sat, 0);
        check("arst_rdcnt", rdcnt, 0);
        @(negedge clk);
        rst = 1'b0;

        run(0, '1, -1, -1, lat, nval, bab);
        check("w0_lat", lat, 11);
        check("w0_nval", nval, 1);
        check("w0_resp", resp, 9'h000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
